// File: rtl/c3_pq_pkg.sv
// Shared command encodings and FSM state type for the c3 priority queue.
package c3_pq_pkg;

  typedef enum logic [2:0] {
    OP_PUSH    = 3'd0,
    OP_POP     = 3'd1,
    OP_PEEK    = 3'd2,
    OP_SIZE    = 3'd3,
    OP_CLEAR   = 3'd4,
    OP_REPLACE = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SIFT_UP   = 2'd1,
    ST_SIFT_DOWN = 2'd2
  } state_e;

endpackage

// File: rtl/c3_pq_cmp.sv
// Strict unsigned heap ordering test: beats_o is high when a_i must sit above b_i.
module c3_pq_cmp #(
  parameter int DATA_W   = 32,
  parameter int MAX_HEAP = 1
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              beats_o
);

  assign beats_o = (MAX_HEAP != 0) ? (a_i > b_i) : (a_i < b_i);

endmodule

// File: rtl/c3_priority_queue.sv
// Binary-heap priority queue with one-level-per-cycle sifting.
// Define C3_PQ_REPLACE_EN to build the REPLACE (pop-and-push in one command) path.
module c3_priority_queue
  import c3_pq_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int MAX_HEAP = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_v,
  input  logic [2:0]        in_op,
  input  logic [4:0]        rd,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_v,
  output logic [4:0]        out_rd,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err,
  output logic              busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int XW = AW + 2;

  state_e            state_q;
  logic [CW-1:0]     count_q;
  logic [AW-1:0]     idx_q;
  logic [DATA_W-1:0] res_q;
  logic [DATA_W-1:0] heap_q [DEPTH];

  logic [CW-1:0]     count_inc, count_dec;
  logic [AW-1:0]     parent_idx, left_idx, right_idx, best_idx;
  logic [XW-1:0]     left_x, right_x;
  logic              left_ok, right_ok;
  logic [DATA_W-1:0] node_val, parent_val, left_val, right_val, right_ref, best_val;
  logic              up_beats, left_beats, right_beats, down_swap;
  logic              is_push, is_pop, is_repl;

  assign busy       = (state_q != ST_IDLE);
  assign count_inc  = count_q + CW'(1);
  assign count_dec  = count_q - CW'(1);
  assign parent_idx = (idx_q - AW'(1)) >> 1;
  assign left_x     = {1'b0, idx_q, 1'b1};
  assign right_x    = left_x + XW'(1);
  assign left_ok    = left_x < XW'(count_q);
  assign right_ok   = right_x < XW'(count_q);
  assign left_idx   = left_x[AW-1:0];
  assign right_idx  = right_x[AW-1:0];

  assign node_val   = heap_q[idx_q];
  assign parent_val = heap_q[parent_idx];
  assign left_val   = heap_q[left_idx];
  assign right_val  = heap_q[right_idx];
  // Right child must strictly beat whichever of node/left is winning so far, so left wins ties.
  assign right_ref  = (left_ok && left_beats) ? left_val : node_val;

  c3_pq_cmp #(.DATA_W(DATA_W), .MAX_HEAP(MAX_HEAP)) u_cmp_up (
    .a_i(node_val), .b_i(parent_val), .beats_o(up_beats));
  c3_pq_cmp #(.DATA_W(DATA_W), .MAX_HEAP(MAX_HEAP)) u_cmp_left (
    .a_i(left_val), .b_i(node_val), .beats_o(left_beats));
  c3_pq_cmp #(.DATA_W(DATA_W), .MAX_HEAP(MAX_HEAP)) u_cmp_right (
    .a_i(right_val), .b_i(right_ref), .beats_o(right_beats));

  always_comb begin
    down_swap = 1'b0;
    best_idx  = idx_q;
    best_val  = node_val;
    if (right_ok && right_beats) begin
      down_swap = 1'b1;
      best_idx  = right_idx;
      best_val  = right_val;
    end else if (left_ok && left_beats) begin
      down_swap = 1'b1;
      best_idx  = left_idx;
      best_val  = left_val;
    end
  end

  always_comb begin
    is_push = (in_op == OP_PUSH);
    is_pop  = (in_op == OP_POP);
    is_repl = 1'b0;
`ifdef C3_PQ_REPLACE_EN
    // REPLACE on an empty heap degenerates to a plain PUSH.
    if (in_op == OP_REPLACE) begin
      if (count_q == '0) is_push = 1'b1;
      else               is_repl = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      idx_q    <= '0;
      res_q    <= '0;
      out_v    <= 1'b0;
      out_err  <= 1'b0;
      out_rd   <= '0;
      out_data <= '0;
    end else begin
      out_v <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (in_v) begin
            out_rd   <= rd;
            out_err  <= 1'b0;
            out_data <= '0;
            if (is_push) begin
              if (count_q == CW'(DEPTH)) begin
                out_v    <= 1'b1;
                out_err  <= 1'b1;
                out_data <= DATA_W'(count_q);
              end else begin
                heap_q[count_q[AW-1:0]] <= in_data;
                count_q <= count_inc;
                idx_q   <= count_q[AW-1:0];
                res_q   <= DATA_W'(count_inc);
                state_q <= ST_SIFT_UP;
              end
            end else if (is_pop || is_repl) begin
              if (count_q == '0) begin
                out_v   <= 1'b1;
                out_err <= 1'b1;
              end else begin
                res_q     <= heap_q[0];
                heap_q[0] <= is_repl ? in_data : heap_q[count_dec[AW-1:0]];
                if (is_pop) count_q <= count_dec;
                idx_q   <= '0;
                state_q <= ST_SIFT_DOWN;
              end
            end else begin
              out_v <= 1'b1;
              case (in_op)
                OP_PEEK: begin
                  if (count_q == '0) out_err  <= 1'b1;
                  else               out_data <= heap_q[0];
                end
                OP_SIZE:  out_data <= DATA_W'(count_q);
                OP_CLEAR: begin
                  out_data <= DATA_W'(count_q);
                  count_q  <= '0;
                end
                default:  out_err <= 1'b1;
              endcase
            end
          end
        end
        ST_SIFT_UP: begin
          if (idx_q != '0 && up_beats) begin
            heap_q[idx_q]      <= parent_val;
            heap_q[parent_idx] <= node_val;
            idx_q              <= parent_idx;
          end else begin
            out_v    <= 1'b1;
            out_data <= res_q;
            state_q  <= ST_IDLE;
          end
        end
        ST_SIFT_DOWN: begin
          if (down_swap) begin
            heap_q[idx_q]    <= best_val;
            heap_q[best_idx] <= node_val;
            idx_q            <= best_idx;
          end else begin
            out_v    <= 1'b1;
            out_data <= res_q;
            state_q  <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
